// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg: load/store size codes, FSM states and the request
// legality rule shared by the memory response unit.
package rv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } memState_t;

  function automatic logic reqLegal(
    input logic       rd,
    input logic       wr,
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic sizeOk;
    logic alignOk;
    if (wr)
      sizeOk = f3 inside {F3_B, F3_H, F3_W};
    else
      sizeOk = f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    if (f3 == F3_W)
      alignOk = (lo == 2'b00);
    else if (f3 == F3_H || f3 == F3_HU)
      alignOk = ~lo[0];
    else
      alignOk = 1'b1;
    return (rd ^ wr) & sizeOk & alignOk;
  endfunction

endpackage

// File: rtl/mem_resp_unit_if.sv
// mem_resp_unit_if: SRAM-side bus of the memory response unit.
// master = the unit, slave = the SRAM.
interface mem_resp_unit_if #(
  parameter int ADDR_W = 12
) ();
  logic              sram_req_out;
  logic              sram_we_out;
  logic [ADDR_W-1:0] sram_addr_out;
  logic [3:0]        sram_be_out;
  logic [31:0]       sram_wdata_out;
  logic [31:0]       sram_rdata_in;
  logic              sram_ack_in;

  modport master (
    output sram_req_out,
    output sram_we_out,
    output sram_addr_out,
    output sram_be_out,
    output sram_wdata_out,
    input  sram_rdata_in,
    input  sram_ack_in
  );

  modport slave (
    input  sram_req_out,
    input  sram_we_out,
    input  sram_addr_out,
    input  sram_be_out,
    input  sram_wdata_out,
    output sram_rdata_in,
    output sram_ack_in
  );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte enables and store replication for a new
// request, lane extraction and extension for the load in flight.
module mem_lane_align
  import rv32_mem_pkg::*;
(
  input  logic [1:0]  reqSize,
  input  logic [1:0]  reqAddrLo,
  input  logic [31:0] wData,
  output logic [3:0]  be,
  output logic [31:0] wDataRep,
  input  logic [2:0]  rspFunct3,
  input  logic [1:0]  rspAddrLo,
  input  logic [31:0] rData,
  output logic [31:0] rDataExt
);
  logic [7:0]  byteLane;
  logic [15:0] halfLane;
  logic        sgn;

  assign byteLane = rData[{rspAddrLo, 3'b000} +: 8];
  assign halfLane = rspAddrLo[1] ? rData[31:16] : rData[15:0];
  assign sgn      = ~rspFunct3[2];

  always_comb begin
    be       = 4'b1111;
    wDataRep = wData;
    unique case (1'b1)
      (reqSize == SZ_B): begin
        be       = 4'b0001 << reqAddrLo;
        wDataRep = {4{wData[7:0]}};
      end
      (reqSize == SZ_H): begin
        be       = reqAddrLo[1] ? 4'b1100 : 4'b0011;
        wDataRep = {2{wData[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rDataExt = rData;
    unique case (1'b1)
      (rspFunct3[1:0] == SZ_B):
        rDataExt = {{24{sgn & byteLane[7]}}, byteLane};
      (rspFunct3[1:0] == SZ_H):
        rDataExt = {{16{sgn & halfLane[15]}}, halfLane};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_resp_unit.sv
// mem_resp_unit: load/store sequencer between the pipeline and a
// single-port SRAM with variable ack latency and a timeout.
module mem_resp_unit
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 15
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            MemRead_in,
  input  logic            MemWrite_in,
  input  logic [2:0]      Funct3_in,
  input  logic [31:0]     Addr_in,
  input  logic [31:0]     WData_in,
  output logic [31:0]     RData_out,
  output logic            Stall_out,
  output logic            Done_out,
  output logic            Err_out,
  mem_resp_unit_if.master sram
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  memState_t        state;
  logic [CNT_W-1:0] tmoCnt;
  logic [2:0]       funct3Q;
  logic [1:0]       addrLoQ;
  logic             legal;
  logic             anyReq;
  logic [3:0]       beReq;
  logic [31:0]      wDataRep;
  logic [31:0]      rDataExt;
  logic             unusedAddr;

  assign legal = reqLegal(MemRead_in, MemWrite_in,
                          Funct3_in, Addr_in[1:0]);
  assign anyReq     = MemRead_in | MemWrite_in;
  assign unusedAddr = ^Addr_in[31:ADDR_W];

  // Gated by reset so a held request cannot stall during reset.
  assign Stall_out = rst_n_in &
                     (((state == IDLE) & legal) |
                      (state == ACCESS));

  mem_lane_align u_align (
    .reqSize   (Funct3_in[1:0]),
    .reqAddrLo (Addr_in[1:0]),
    .wData     (WData_in),
    .be        (beReq),
    .wDataRep  (wDataRep),
    .rspFunct3 (funct3Q),
    .rspAddrLo (addrLoQ),
    .rData     (sram.sram_rdata_in),
    .rDataExt  (rDataExt)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state               <= IDLE;
      tmoCnt              <= '0;
      funct3Q             <= '0;
      addrLoQ             <= '0;
      RData_out           <= '0;
      Done_out            <= 1'b0;
      Err_out             <= 1'b0;
      sram.sram_req_out   <= 1'b0;
      sram.sram_we_out    <= 1'b0;
      sram.sram_addr_out  <= '0;
      sram.sram_be_out    <= '0;
      sram.sram_wdata_out <= '0;
    end else begin
      Done_out <= 1'b0;
      Err_out  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (legal) begin
            state               <= ACCESS;
            tmoCnt              <= '0;
            funct3Q             <= Funct3_in;
            addrLoQ             <= Addr_in[1:0];
            sram.sram_req_out   <= 1'b1;
            sram.sram_we_out    <= MemWrite_in;
            sram.sram_addr_out  <= {Addr_in[ADDR_W-1:2], 2'b00};
            sram.sram_be_out    <= beReq;
            sram.sram_wdata_out <= wDataRep;
          end else if (anyReq) begin
            Err_out <= 1'b1;
          end
        end
        ACCESS: begin
          // Ack is tested first so it wins over a same-cycle timeout.
          if (sram.sram_ack_in) begin
            if (!sram.sram_we_out)
              RData_out <= rDataExt;
            Done_out          <= 1'b1;
            sram.sram_req_out <= 1'b0;
            sram.sram_we_out  <= 1'b0;
            state             <= DONE;
          end else if (tmoCnt == CNT_W'(TIMEOUT - 1)) begin
            Err_out           <= 1'b1;
            sram.sram_req_out <= 1'b0;
            sram.sram_we_out  <= 1'b0;
            state             <= DONE;
          end else begin
            tmoCnt <= tmoCnt + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_resp_unit.md
MEM_RESP_UNIT -- requirements
Module: mem_resp_unit

Interface
REQ-001 Parameter ADDR_W, default 12, byte-address width presented to SRAM.
REQ-002 Parameter TIMEOUT, default 15, max cycles waiting for sram_ack_in.
REQ-003 clk_in  input  1  single clock; all state on rising edge.
REQ-004 rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-005 MemRead_in  input  1  load request from control unit, held until Stall_out low.
REQ-006 MemWrite_in  input  1  store request from control unit, held until Stall_out low.
REQ-007 Funct3_in  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 Addr_in  input  32  byte address from ALU.
REQ-009 WData_in  input  32  store data (rs2).
REQ-010 RData_out  output  32  load result, extended, held until next load completes.
REQ-011 Stall_out  output  1  processor must hold current instruction.
REQ-012 Done_out  output  1  one-cycle pulse, access completed.
REQ-013 Err_out  output  1  one-cycle pulse: misaligned, illegal Funct3, read+write together, or timeout.
REQ-014 sram_req_out / sram_we_out  output  1 each  SRAM request and write strobe.
REQ-015 sram_addr_out  output  ADDR_W  word-aligned address (Addr_in[ADDR_W-1:2], low bits 00).
REQ-016 sram_be_out  output  4  byte enables; sram_wdata_out  output  32  lane-replicated store data.
REQ-017 sram_rdata_in  input  32  read word, valid with ack; sram_ack_in  input  1  access complete.

Function
REQ-018 FSM states IDLE, ACCESS, DONE; request evaluated only in IDLE.
REQ-019 IDLE, exactly one of MemRead_in/MemWrite_in high and checks pass -> latch address/size/data/direction, go ACCESS.
REQ-020 Checks: W needs Addr_in[1:0]=00; H/HU need Addr_in[0]=0; stores accept only 000/001/010; loads reject 011/110/111.
REQ-021 Check fails or both requests high -> Err_out pulse next cycle, no SRAM request, stay IDLE, Stall_out low.
REQ-022 Stall_out = (IDLE and legal request) or ACCESS; low in DONE.
REQ-023 ACCESS: sram_req_out high, sram_we_out = latched direction, outputs stable until ack or timeout.
REQ-024 Byte enables: B/BU 0001<<addr[1:0]; H/HU 0011 (addr[1]=0) or 1100; W 1111; loads same mask.
REQ-025 Store data: B replicates byte 4x, H replicates halfword 2x, W passthrough.
REQ-026 sram_ack_in in ACCESS -> loads capture selected lane into RData_out (B/H sign-extend, BU/HU zero-extend), go DONE.
REQ-027 Minimum latency request-to-Done_out: 2 cycles for ack in first ACCESS cycle; +1 per ack delay cycle.
REQ-028 Timeout counter clears on ACCESS entry, increments each ACCESS cycle without ack; reaching TIMEOUT -> Err_out pulse, drop request, go DONE, RData_out unchanged.
REQ-029 Ack and timeout same cycle -> ack wins, no error.
REQ-030 DONE lasts exactly one cycle, Done_out high (not on timeout), then IDLE; held requests in DONE ignored.
REQ-031 sram_ack_in outside ACCESS ignored.

Reset
REQ-032 rst_n_in low -> state IDLE, counter 0, RData_out 0, Stall_out/Done_out/Err_out/sram_req_out/sram_we_out 0, sram_be_out 0000, sram_addr_out/sram_wdata_out 0.
REQ-033 Reset mid-ACCESS aborts immediately; no Done_out/Err_out after release.

Structure
REQ-034 Package rv32_mem_pkg holds Funct3 load/store constants and the state enum.
REQ-035 Sub-module mem_lane_align: combinational byte-enable, store replication, load extraction/extension.

Verification
REQ-036 LW 0x100, ack after 2 cycles, rdata 0xDEADBEEF -> be 1111, Stall 3 cycles, Done pulse, RData_out 0xDEADBEEF.
REQ-037 LB 0x103, rdata 0x80FFFFFF -> be 1000, RData_out 0xFFFFFF80; LBU same -> 0x00000080.
REQ-038 SH 0x102, WData 0x0000ABCD -> we 1, be 1100, wdata 0xABCDABCD, Done pulse.
REQ-039 LW 0x102 -> Err_out pulse, sram_req_out never high, Stall_out low.
REQ-040 LW, no ack -> sram_req_out high 15 cycles, Err_out pulse, no Done_out, back to IDLE.
REQ-041 rst_n_in low during ACCESS -> all outputs zero same cycle, no pulses afterwards.
